// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 geometry, counter width
// and sync polarity. The text generator imports this for its screen bounds.
package vga_timing_pkg;

    // Default horizontal geometry, in pixels
    localparam int H_DISP = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    // Default vertical geometry, in lines
    localparam int V_DISP = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    // Derived totals (800 x 525 for the defaults)
    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

    // Pixel/line counters are 10 bits, so neither total may exceed 1024
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1024;

    typedef logic [CNT_W-1:0] cnt_t;

    // Both syncs are active low
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    // True when lo <= val < hi
    function automatic logic in_window(input cnt_t val, input int lo, input int hi);
        int v_i;
        v_i = int'(val);
        return (v_i >= lo) && (v_i < hi);
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-enable divider: p_tick is a registered one-cycle pulse every DIV
// clk_i cycles, high while the divider phase sits at DIV-1. With DIV=1 the
// pulse is permanently high from the first cycle after reset.
module vga_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic p_tick
);

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

    generate
        if (DIV < 1 || DIV > 15) begin : g_bad_div
            $error("vga_tick_div: DIV must be in 1..15");
        end
    endgenerate

    logic [3:0] div_cnt_r;
    logic [3:0] div_next_s;
    logic       p_tick_r;

    // Next divider phase, wrapping back to zero after DIV-1
    always_comb begin
        div_next_s = 4'd0;
        if (div_cnt_r == DIV_LAST) begin
            div_next_s = 4'd0;
        end else begin
            div_next_s = div_cnt_r + 4'd1;
        end
    end

    // Phase register; the tick is decoded from the next phase so it is high exactly while the phase equals DIV-1
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            div_cnt_r <= 4'd0;
            p_tick_r  <= 1'b0;
        end else begin
            div_cnt_r <= div_next_s;
            p_tick_r  <= (div_next_s == DIV_LAST);
        end
    end

    assign p_tick = p_tick_r;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters advanced by a pixel-enable tick
// from the board clock, with registered hsync/vsync/video_on decode.
// Optional macro VGA_FRAME_CNT_EN adds an 8-bit completed-frame counter;
// without it frame_cnt is tied to zero and no counter flops exist.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int DIV    = 4,
    parameter int H_DISP = vga_timing_pkg::H_DISP,
    parameter int H_FP   = vga_timing_pkg::H_FP,
    parameter int H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int H_BP   = vga_timing_pkg::H_BP,
    parameter int V_DISP = vga_timing_pkg::V_DISP,
    parameter int V_FP   = vga_timing_pkg::V_FP,
    parameter int V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int V_BP   = vga_timing_pkg::V_BP
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int   H_TOT_L  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT_L  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST   = cnt_t'(H_TOT_L - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOT_L - 1);
    localparam int   HS_START = H_DISP + H_FP;
    localparam int   HS_END   = H_DISP + H_FP + H_SYNC;
    localparam int   VS_START = V_DISP + V_FP;
    localparam int   VS_END   = V_DISP + V_FP + V_SYNC;

    generate
        if (H_TOT_L > CNT_MAX || V_TOT_L > CNT_MAX) begin : g_bad_timing
            $error("vga_sync_gen: H_TOT and V_TOT must not exceed 1024");
        end
    endgenerate

    logic p_tick_s;
    cnt_t h_cnt_r;
    cnt_t v_cnt_r;
    cnt_t h_next_s;
    cnt_t v_next_s;
    logic frame_wrap_s;
    logic hsync_next_s;
    logic vsync_next_s;
    logic video_on_next_s;
    logic hsync_r;
    logic vsync_r;
    logic video_on_r;
    logic frame_start_r;

    vga_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .p_tick  (p_tick_s)
    );

    // Next counter values: step on the tick, wrap at end of line and end of frame together
    always_comb begin
        h_next_s     = h_cnt_r;
        v_next_s     = v_cnt_r;
        frame_wrap_s = 1'b0;
        if (p_tick_s) begin
            if (h_cnt_r == H_LAST) begin
                h_next_s = 10'd0;
                if (v_cnt_r == V_LAST) begin
                    v_next_s     = 10'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    v_next_s = v_cnt_r + 10'd1;
                end
            end else begin
                h_next_s = h_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r;
            v_next_s = v_cnt_r;
        end
    end

    // Decode sync and blanking from the next counter values so they register alongside them
    always_comb begin
        hsync_next_s    = SYNC_IDLE;
        vsync_next_s    = SYNC_IDLE;
        video_on_next_s = 1'b0;
        if (in_window(h_next_s, HS_START, HS_END)) begin
            hsync_next_s = SYNC_ACTIVE;
        end else begin
            hsync_next_s = SYNC_IDLE;
        end
        if (in_window(v_next_s, VS_START, VS_END)) begin
            vsync_next_s = SYNC_ACTIVE;
        end else begin
            vsync_next_s = SYNC_IDLE;
        end
        if (in_window(h_next_s, 0, H_DISP) && in_window(v_next_s, 0, V_DISP)) begin
            video_on_next_s = 1'b1;
        end else begin
            video_on_next_s = 1'b0;
        end
    end

    // Counter and output registers; reset abandons any partial line immediately
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            hsync_r       <= SYNC_IDLE;
            vsync_r       <= SYNC_IDLE;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            video_on_r    <= video_on_next_s;
            frame_start_r <= frame_wrap_s;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_r;

    // Completed-frame count, stepped on the same edge that raises frame_start
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            frame_cnt_r <= 8'd0;
        end else if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 8'h00;
`endif

    // The counter registers are the pixel position outputs, so no duplicate flops are needed
    assign pix_x       = h_cnt_r;
    assign pix_y       = v_cnt_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign video_on    = video_on_r;
    assign p_tick      = p_tick_s;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Instance A: DIV=4, full 800-pixel lines, short
// 12-line frame so whole frames fit the run. Instance B: DIV=1, tiny 12x7
// frame, used to roll frame_cnt past 255. A cycle-count reference model
// feeds a scoreboard queue every clock; directed checks cover boundaries.
module tb_vga_sync_gen;

    localparam int DA = 4;
    localparam int HD_A = 640, HF_A = 16, HS_A = 96, HB_A = 48;
    localparam int VD_A = 6, VF_A = 2, VS_A = 2, VB_A = 2;
    localparam int DB = 1;
    localparam int HD_B = 8, HF_B = 1, HS_B = 2, HB_B = 1;
    localparam int VD_B = 4, VF_B = 1, VS_B = 1, VB_B = 1;
    localparam int LIMIT = 45000;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_a_n, rst_b_n;
    logic [9:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
    logic hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a;
    logic hsync_b, vsync_b, video_on_b, p_tick_b, frame_start_b;
    logic [7:0] frame_cnt_a, frame_cnt_b;
    obs_t obs_a, obs_b;

    assign obs_a = {pix_x_a, pix_y_a, hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a, frame_cnt_a};
    assign obs_b = {pix_x_b, pix_y_b, hsync_b, vsync_b, video_on_b, p_tick_b, frame_start_b, frame_cnt_b};

    vga_sync_gen #(
        .DIV(DA), .H_DISP(HD_A), .H_FP(HF_A), .H_SYNC(HS_A), .H_BP(HB_A),
        .V_DISP(VD_A), .V_FP(VF_A), .V_SYNC(VS_A), .V_BP(VB_A)
    ) u_dut_a (
        .clk_i(clk_i), .rst_n_i(rst_a_n), .pix_x(pix_x_a), .pix_y(pix_y_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .p_tick(p_tick_a),
        .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_sync_gen #(
        .DIV(DB), .H_DISP(HD_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
        .V_DISP(VD_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B)
    ) u_dut_b (
        .clk_i(clk_i), .rst_n_i(rst_b_n), .pix_x(pix_x_b), .pix_y(pix_y_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .p_tick(p_tick_b),
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    int   total = 0;
    int   bad = 0;
    int   ta = 0;
    int   tb = 0;
    int   last_tick_a = 0;
    int   tick_cnt_a = 0;
    int   fs_seen_b = 0;
    obs_t exp_qa[$];
    obs_t exp_qb[$];

    // Expected outputs t clocks after the reset-release edge (t=0: still in reset).
    // The first tick is in the cycle after edge DIV-1 (edge 1 when DIV=1), and the
    // counters step on the edge that follows it.
    function automatic obs_t model(input int t, input int div, input int hd, input int hfp,
                                   input int hsw, input int hbp, input int vd, input int vfp,
                                   input int vsw, input int vbp);
        obs_t o;
        int htot, vtot, n, frames, p, h, v;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (t > 0) begin
            htot   = hd + hfp + hsw + hbp;
            vtot   = vd + vfp + vsw + vbp;
            n      = (div == 1) ? t - 1 : t / div;
            frames = n / (htot * vtot);
            p      = n % (htot * vtot);
            h      = p % htot;
            v      = p / htot;
            o.x    = 10'(h);
            o.y    = 10'(v);
            o.hs   = !((h >= hd + hfp) && (h < hd + hfp + hsw));
            o.vs   = !((v >= vd + vfp) && (v < vd + vfp + vsw));
            o.von  = (h < hd) && (v < vd);
            o.pt   = ((t % div) == div - 1);
            o.fs   = ((t % div) == 0) && (t >= 2) && (p == 0) && (frames > 0);
`ifdef VGA_FRAME_CNT_EN
            o.fc   = 8'(frames % 256);
`else
            o.fc   = 8'h00;
`endif
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: push model expectations for both instances, then pop and compare after the edge
    task automatic step();
        obs_t ea, eb;
        @(posedge clk_i);
        if (rst_a_n) ta++; else ta = 0;
        if (rst_b_n) tb++; else tb = 0;
        exp_qa.push_back(model(ta, DA, HD_A, HF_A, HS_A, HB_A, VD_A, VF_A, VS_A, VB_A));
        exp_qb.push_back(model(tb, DB, HD_B, HF_B, HS_B, HB_B, VD_B, VF_B, VS_B, VB_B));
        #1;
        ea = exp_qa.pop_front();
        eb = exp_qb.pop_front();
        total++;
        assert (obs_a === ea) else begin
            bad++;
            $error("FAIL trace_a t=%0d observed=%h expected=%h", ta, obs_a, ea);
        end
        total++;
        assert (obs_b === eb) else begin
            bad++;
            $error("FAIL trace_b t=%0d observed=%h expected=%h", tb, obs_b, eb);
        end
        if (ta == 0) begin
            last_tick_a = 0;
            tick_cnt_a  = 0;
        end else if (p_tick_a === 1'b1) begin
            if (last_tick_a > 0) check("tick_gap", 32'(ta - last_tick_a), 32'(DA));
            last_tick_a = ta;
            tick_cnt_a++;
        end
        if (tb > 0 && frame_start_b === 1'b1) begin
            fs_seen_b++;
            if (fs_seen_b >= 255 && fs_seen_b <= 257) begin
`ifdef VGA_FRAME_CNT_EN
                check("frame_cnt_roll", 32'(frame_cnt_b), 32'(fs_seen_b % 256));
`else
                check("frame_cnt_off", 32'(frame_cnt_b), 32'd0);
`endif
            end
        end
    endtask

    int n;
    logic [9:0] prev_x, prev_y;

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("rst_pix_x", 32'(pix_x_a), 32'd0);
        check("rst_pix_y", 32'(pix_y_a), 32'd0);
        check("rst_hsync", 32'(hsync_a), 32'd1);
        check("rst_vsync", 32'(vsync_a), 32'd1);
        check("rst_video_on", 32'(video_on_a), 32'd0);
        check("rst_p_tick", 32'(p_tick_a), 32'd0);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        step();
        check("rel_video_on", 32'(video_on_a), 32'd1);
        check("rel_frame_start", 32'(frame_start_a), 32'd0);
        step();
        step();
        check("rel_pix_x_hold", 32'(pix_x_a), 32'd0);
        step();
        check("rel_pix_x_step", 32'(pix_x_a), 32'd1);

        // Horizontal boundaries along line 0
        n = 0;
        prev_x = pix_x_a;
        while (video_on_a !== 1'b0 && n < LIMIT) begin prev_x = pix_x_a; step(); n++; end
        check("von_fall_bound", 32'(n < LIMIT), 32'd1);
        check("von_fall_prev_x", 32'(prev_x), 32'd639);
        check("von_fall_x", 32'(pix_x_a), 32'd640);
        n = 0;
        while (hsync_a !== 1'b0 && n < LIMIT) begin step(); n++; end
        check("hs_fall_x", 32'(pix_x_a), 32'd656);
        n = 0;
        while (hsync_a !== 1'b1 && n < LIMIT) begin step(); n++; end
        check("hs_rise_x", 32'(pix_x_a), 32'd752);
        n = 0;
        while (pix_y_a !== 10'd1 && n < LIMIT) begin prev_x = pix_x_a; step(); n++; end
        check("hwrap_prev_x", 32'(prev_x), 32'd799);
        check("hwrap_x", 32'(pix_x_a), 32'd0);
        check("line_clocks", 32'(ta), 32'd3200);

        // Vertical window and frame wrap
        n = 0;
        while (vsync_a !== 1'b0 && n < LIMIT) begin step(); n++; end
        check("vs_fall_y", 32'(pix_y_a), 32'(VD_A + VF_A));
        check("vs_fall_x", 32'(pix_x_a), 32'd0);
        n = 0;
        while (vsync_a !== 1'b1 && n < LIMIT) begin step(); n++; end
        check("vs_rise_y", 32'(pix_y_a), 32'(VD_A + VF_A + VS_A));
        n = 0;
        while (frame_start_a !== 1'b1 && n < LIMIT) begin
            prev_x = pix_x_a; prev_y = pix_y_a; step(); n++;
        end
        check("fwrap_bound", 32'(n < LIMIT), 32'd1);
        check("fwrap_prev_x", 32'(prev_x), 32'd799);
        check("fwrap_prev_y", 32'(prev_y), 32'd11);
        check("fwrap_x", 32'(pix_x_a), 32'd0);
        check("fwrap_y", 32'(pix_y_a), 32'd0);
        check("frame_ticks", 32'(tick_cnt_a), 32'd9600);
        step();
        check("fs_single", 32'(frame_start_a), 32'd0);

        // Reset in the middle of the second frame
        n = 0;
        while (!(pix_x_a === 10'd700 && pix_y_a === 10'd5) && n < LIMIT) begin step(); n++; end
        check("mid_bound", 32'(n < LIMIT), 32'd1);
        rst_a_n = 1'b0;
        step();
        check("mid_pix_x", 32'(pix_x_a), 32'd0);
        check("mid_pix_y", 32'(pix_y_a), 32'd0);
        check("mid_hsync", 32'(hsync_a), 32'd1);
        check("mid_vsync", 32'(vsync_a), 32'd1);
        step();
        rst_a_n = 1'b1;
        step();
        check("resume_video_on", 32'(video_on_a), 32'd1);
        check("resume_pix_x", 32'(pix_x_a), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("resume_pix_x_step", 32'(pix_x_a), 32'd1);
        for (int i = 0; i < 100; i++) step();

        check("frames_seen_b", 32'(fs_seen_b >= 257), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
